// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin share of the ROB write-back bus between RS, LB and SB one-entry slots, with a registered CDB result and a saturating conflict counter
module cdb_arbiter #(
  parameter int ROB_WIDTH_BIT = 3
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     clear_all,
  input  logic                     rs_valid,
  input  logic [31:0]              rs_value,
  input  logic [ROB_WIDTH_BIT-1:0] rs_dest,
  input  logic [31:0]              rs_jalr_pc,
  output logic                     rs_ready,
  input  logic                     lb_valid,
  input  logic [31:0]              lb_value,
  input  logic [ROB_WIDTH_BIT-1:0] lb_dest,
  output logic                     lb_ready,
  input  logic                     sb_valid,
  input  logic [ROB_WIDTH_BIT-1:0] sb_dest,
  output logic                     sb_ready,
  output logic                     cdb_valid,
  output logic [1:0]               cdb_src,
  output logic [31:0]              cdb_value,
  output logic [ROB_WIDTH_BIT-1:0] cdb_dest,
  output logic [31:0]              cdb_jalr_pc,
  output logic [15:0]              conflict_cnt
);
  logic [2:0] full, g, acc;
  logic [1:0] rr, gi;
  logic act, multi;
  logic [31:0] rs_val_q, rs_jalr_q, lb_val_q;
  logic [ROB_WIDTH_BIT-1:0] rs_dest_q, lb_dest_q, sb_dest_q;
  always_comb begin
    act = rdy_in && !clear_all;
    gi = rr == 2'd0 ? (full[0] ? 2'd0 : full[1] ? 2'd1 : 2'd2) :
         rr == 2'd1 ? (full[1] ? 2'd1 : full[2] ? 2'd2 : 2'd0) :
                      (full[2] ? 2'd2 : full[0] ? 2'd0 : 2'd1);
    g = act && |full ? 3'b001 << gi : 3'b000;
    rs_ready = act && (!full[0] || g[0]);
    lb_ready = act && (!full[1] || g[1]);
    sb_ready = act && (!full[2] || g[2]);
    acc = {sb_valid && sb_ready, lb_valid && lb_ready, rs_valid && rs_ready};
    multi = (full[0] && full[1]) || (full[0] && full[2]) || (full[1] && full[2]);
  end
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      full <= 3'b000;
      rr <= 2'd0;
      cdb_valid <= 1'b0;
      cdb_src <= 2'd0;
      cdb_value <= 32'd0;
      cdb_dest <= '0;
      cdb_jalr_pc <= 32'd0;
      conflict_cnt <= 16'd0;
    end else if (rdy_in && clear_all) begin
      full <= 3'b000;
      rr <= 2'd0;
      cdb_valid <= 1'b0;
    end else if (rdy_in) begin
      full <= (full & ~g) | acc;
      if (acc[0]) begin
        rs_val_q <= rs_value;
        rs_dest_q <= rs_dest;
        rs_jalr_q <= rs_jalr_pc;
      end
      if (acc[1]) begin
        lb_val_q <= lb_value;
        lb_dest_q <= lb_dest;
      end
      if (acc[2]) sb_dest_q <= sb_dest;
      cdb_valid <= |g;
      if (|g) begin
        rr <= gi == 2'd2 ? 2'd0 : gi + 2'd1;
        cdb_src <= gi;
        cdb_value <= gi == 2'd0 ? rs_val_q : gi == 2'd1 ? lb_val_q : 32'd0;
        cdb_dest <= gi == 2'd0 ? rs_dest_q : gi == 2'd1 ? lb_dest_q : sb_dest_q;
        cdb_jalr_pc <= gi == 2'd0 ? rs_jalr_q : 32'd0;
      end
      if (multi && conflict_cnt != 16'hffff) conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: table-driven directed check of cdb_arbiter plus a conflict counter saturation run
module tb_cdb_arbiter;
  logic clk_in = 1'b0;
  logic rst_in, rdy_in, clear_all;
  logic rs_valid, lb_valid, sb_valid, rs_ready, lb_ready, sb_ready;
  logic [31:0] rs_value, rs_jalr_pc, lb_value, cdb_value, cdb_jalr_pc;
  logic [2:0] rs_dest, lb_dest, sb_dest, cdb_dest;
  logic cdb_valid;
  logic [1:0] cdb_src;
  logic [15:0] conflict_cnt;
  int errors = 0, checks = 0;
  always #5 clk_in = ~clk_in;
  cdb_arbiter #(.ROB_WIDTH_BIT(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_all(clear_all),
    .rs_valid(rs_valid), .rs_value(rs_value), .rs_dest(rs_dest), .rs_jalr_pc(rs_jalr_pc), .rs_ready(rs_ready),
    .lb_valid(lb_valid), .lb_value(lb_value), .lb_dest(lb_dest), .lb_ready(lb_ready),
    .sb_valid(sb_valid), .sb_dest(sb_dest), .sb_ready(sb_ready),
    .cdb_valid(cdb_valid), .cdb_src(cdb_src), .cdb_value(cdb_value), .cdb_dest(cdb_dest),
    .cdb_jalr_pc(cdb_jalr_pc), .conflict_cnt(conflict_cnt)
  );
  typedef struct {
    logic rst, rdy, clr, rv;
    logic [31:0] rval;
    logic [2:0] rdst;
    logic [31:0] rj;
    logic lv;
    logic [31:0] lval;
    logic [2:0] ldst;
    logic sv;
    logic [2:0] sdst;
    logic cr;
    logic [2:0] erdy;
    logic [86:0] eout;
  } vec_t;
  vec_t q[$];
  function automatic vec_t mk(logic rst, logic rdy, logic clr, logic rv, logic [31:0] rval, logic [2:0] rdst,
                              logic [31:0] rj, logic lv, logic [31:0] lval, logic [2:0] ldst, logic sv,
                              logic [2:0] sdst, logic cr, logic [2:0] erdy, logic ev, logic [1:0] esrc,
                              logic [31:0] eval, logic [2:0] edst, logic [31:0] ej, logic [15:0] ecnt);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.clr = clr; v.rv = rv; v.rval = rval; v.rdst = rdst; v.rj = rj;
    v.lv = lv; v.lval = lval; v.ldst = ldst; v.sv = sv; v.sdst = sdst; v.cr = cr; v.erdy = erdy;
    v.eout = {ev, esrc, eval, edst, ej, ecnt};
    return v;
  endfunction
  function automatic logic [86:0] outs();
    return {cdb_valid, cdb_src, cdb_value, cdb_dest, cdb_jalr_pc, conflict_cnt};
  endfunction
  task automatic chk_out(string name, logic [86:0] exp);
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("FAIL %s: {valid,src,value,dest,jalr,cnt} got %h want %h", name, outs(), exp);
    end
  endtask
  task automatic chk_rdy(string name, logic [2:0] exp);
    checks++;
    if ({rs_ready, lb_ready, sb_ready} !== exp) begin
      errors++;
      $display("FAIL %s: ready{rs,lb,sb} got %b want %b", name, {rs_ready, lb_ready, sb_ready}, exp);
    end
  endtask
  initial begin
    rst_in = 0; rdy_in = 1; clear_all = 0;
    rs_valid = 0; rs_value = 0; rs_dest = 0; rs_jalr_pc = 0;
    lb_valid = 0; lb_value = 0; lb_dest = 0; sb_valid = 0; sb_dest = 0;
    q.push_back(mk(0,1,0, 0,0,0,0, 0,0,0, 0,0, 0,3'b000, 0,0,0,0,0,0));
    q.push_back(mk(0,1,0, 0,0,0,0, 0,0,0, 0,0, 1,3'b111, 0,0,0,0,0,0));
    q.push_back(mk(1,1,0, 0,0,0,0, 0,0,0, 0,0, 1,3'b111, 0,0,0,0,0,0));
    q.push_back(mk(1,1,0, 1,'h11,1,'h2000, 1,'hAB,2, 1,4, 1,3'b111, 0,0,0,0,0,0));
    q.push_back(mk(1,1,0, 0,0,0,0, 0,0,0, 0,0, 1,3'b100, 1,0,'h11,1,'h2000,1));
    q.push_back(mk(1,1,0, 0,0,0,0, 0,0,0, 0,0, 1,3'b110, 1,1,'hAB,2,0,2));
    q.push_back(mk(1,1,0, 0,0,0,0, 0,0,0, 0,0, 1,3'b111, 1,2,0,4,0,2));
    q.push_back(mk(1,1,0, 0,0,0,0, 0,0,0, 0,0, 1,3'b111, 0,2,0,4,0,2));
    q.push_back(mk(1,1,0, 1,'h12,3,'h1000, 0,0,0, 0,0, 1,3'b111, 0,2,0,4,0,2));
    q.push_back(mk(1,1,0, 0,0,0,0, 0,0,0, 0,0, 1,3'b111, 1,0,'h12,3,'h1000,2));
    q.push_back(mk(1,1,0, 0,0,0,0, 0,0,0, 0,0, 1,3'b111, 0,0,'h12,3,'h1000,2));
    q.push_back(mk(1,1,0, 1,'h21,5,'h3000, 1,'h31,6, 0,0, 1,3'b111, 0,0,'h12,3,'h1000,2));
    q.push_back(mk(1,1,0, 1,'h22,5,'h3004, 1,'h32,6, 0,0, 1,3'b011, 1,1,'h31,6,0,3));
    q.push_back(mk(1,1,0, 1,'h22,5,'h3004, 1,'h33,6, 0,0, 1,3'b101, 1,0,'h21,5,'h3000,4));
    q.push_back(mk(1,1,0, 1,'h23,5,'h3008, 1,'h33,6, 0,0, 1,3'b011, 1,1,'h32,6,0,5));
    q.push_back(mk(1,1,0, 1,'h23,5,'h3008, 1,'h34,6, 0,0, 1,3'b101, 1,0,'h22,5,'h3004,6));
    q.push_back(mk(1,1,0, 0,0,0,0, 1,'h44,2, 1,7, 1,3'b011, 1,1,'h33,6,0,7));
    q.push_back(mk(1,1,1, 1,'h55,0,0, 0,0,0, 0,0, 1,3'b000, 0,1,'h33,6,0,7));
    q.push_back(mk(1,1,0, 0,0,0,0, 0,0,0, 0,0, 1,3'b111, 0,1,'h33,6,0,7));
    q.push_back(mk(1,1,0, 1,'h66,1,'h40, 0,0,0, 1,3, 1,3'b111, 0,1,'h33,6,0,7));
    q.push_back(mk(1,1,0, 0,0,0,0, 0,0,0, 0,0, 1,3'b110, 1,0,'h66,1,'h40,8));
    q.push_back(mk(1,1,0, 0,0,0,0, 0,0,0, 0,0, 1,3'b111, 1,2,0,3,0,8));
    q.push_back(mk(1,1,0, 1,'h77,2,'h50, 0,0,0, 0,0, 1,3'b111, 0,2,0,3,0,8));
    q.push_back(mk(1,1,0, 1,'h78,4,'h54, 0,0,0, 0,0, 1,3'b111, 1,0,'h77,2,'h50,8));
    for (int i = 0; i < 3; i++)
      q.push_back(mk(1,0,0, 1,'h79,1,'h58, 1,'h99,5, 0,0, 1,3'b000, 1,0,'h77,2,'h50,8));
    q.push_back(mk(1,1,0, 0,0,0,0, 0,0,0, 0,0, 1,3'b111, 1,0,'h78,4,'h54,8));
    q.push_back(mk(1,1,0, 0,0,0,0, 0,0,0, 0,0, 1,3'b111, 0,0,'h78,4,'h54,8));
    q.push_back(mk(1,1,0, 1,'h88,6,'h60, 1,'h89,7, 0,0, 1,3'b111, 0,0,'h78,4,'h54,8));
    q.push_back(mk(0,0,1, 1,'h90,1,0, 0,0,0, 0,0, 1,3'b000, 0,0,0,0,0,0));
    q.push_back(mk(1,1,0, 0,0,0,0, 0,0,0, 0,0, 1,3'b111, 0,0,0,0,0,0));
    q.push_back(mk(1,1,0, 0,0,0,0, 0,0,0, 0,0, 1,3'b111, 0,0,0,0,0,0));
    foreach (q[i]) begin
      @(negedge clk_in);
      rst_in = q[i].rst; rdy_in = q[i].rdy; clear_all = q[i].clr;
      rs_valid = q[i].rv; rs_value = q[i].rval; rs_dest = q[i].rdst; rs_jalr_pc = q[i].rj;
      lb_valid = q[i].lv; lb_value = q[i].lval; lb_dest = q[i].ldst;
      sb_valid = q[i].sv; sb_dest = q[i].sdst;
      #1;
      if (q[i].cr) chk_rdy($sformatf("vec%0d_ready", i), q[i].erdy);
      @(posedge clk_in);
      #1;
      chk_out($sformatf("vec%0d_cdb", i), q[i].eout);
    end
    @(negedge clk_in);
    rst_in = 1; rdy_in = 1; clear_all = 0;
    rs_valid = 1; rs_value = 32'h5; rs_dest = 3'd1; rs_jalr_pc = 32'h0;
    lb_valid = 1; lb_value = 32'h6; lb_dest = 3'd2; sb_valid = 0;
    repeat (65540) @(posedge clk_in);
    #1;
    checks++;
    if (conflict_cnt !== 16'hffff) begin
      errors++;
      $display("FAIL sat_cnt: conflict_cnt got %h want ffff", conflict_cnt);
    end
    checks++;
    if (cdb_valid !== 1'b1) begin
      errors++;
      $display("FAIL sat_throughput: cdb_valid got %b want 1", cdb_valid);
    end
    @(posedge clk_in);
    #1;
    checks++;
    if (conflict_cnt !== 16'hffff) begin
      errors++;
      $display("FAIL sat_hold: conflict_cnt got %h want ffff", conflict_cnt);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
